acp_arbiter: RTL

Two-requester arbiter for the 64-bit ACP master port between the accelerator's engines and the PS. It shares the AR/R and AW/W/B channels between requester 0 and requester 1 with independent round-robin read and write arbitration. Each grant lasts one whole burst, so beats of different requesters never interleave. It sits between the accelerator's DMA engines and the `axi_ext_master_conn_0_S_AXI_*` signals.

---
 rtl/acp_pkg.sv | 26 ++
 rtl/acp_rr_pick.sv | 12 +
 rtl/acp_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/acp_pkg.sv
// Shared types and constants for the two-requester ACP arbiter.
package acp_pkg;

    localparam int ACP_AW_DEFAULT = 32;
    localparam int ACP_DW_DEFAULT = 64;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    // Non-coherent traffic bypasses the SCU; coherent traffic is snooped through it.
    localparam logic [3:0] ACP_CACHE_DEFAULT  = 4'b0011;
    localparam logic [4:0] ACP_USER_DEFAULT   = 5'b00000;
    localparam logic [3:0] ACP_CACHE_COHERENT = 4'b1111;
    localparam logic [4:0] ACP_USER_COHERENT  = 5'b00001;

endpackage

// File: rtl/acp_rr_pick.sv
// Two-way round-robin pick: ptr names the requester preferred when both request.
module acp_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant_valid,
    output logic       grant_id
);

    assign grant_valid = |req;
    assign grant_id    = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/acp_arbiter.sv
// Two-requester burst-level round-robin arbiter for the ACP master port.
// Define ACP_ARB_COHERENT_EN to tag all traffic coherent (cache 4'b1111, user 5'b00001).
module acp_arbiter
    import acp_pkg::*;
#(
    parameter int AW = ACP_AW_DEFAULT,
    parameter int DW = ACP_DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   s0_araddr,
    input  logic [7:0]      s0_arlen,
    input  logic [2:0]      s0_arsize,
    input  logic [1:0]      s0_arburst,
    input  logic [2:0]      s0_arprot,
    input  logic            s0_arvalid,
    output logic            s0_arready,
    output logic [DW-1:0]   s0_rdata,
    output logic [1:0]      s0_rresp,
    output logic            s0_rlast,
    output logic            s0_rvalid,
    input  logic            s0_rready,
    input  logic [AW-1:0]   s0_awaddr,
    input  logic [7:0]      s0_awlen,
    input  logic [2:0]      s0_awsize,
    input  logic [1:0]      s0_awburst,
    input  logic [2:0]      s0_awprot,
    input  logic            s0_awvalid,
    output logic            s0_awready,
    input  logic [DW-1:0]   s0_wdata,
    input  logic [DW/8-1:0] s0_wstrb,
    input  logic            s0_wlast,
    input  logic            s0_wvalid,
    output logic            s0_wready,
    output logic [1:0]      s0_bresp,
    output logic            s0_bvalid,
    input  logic            s0_bready,
    input  logic [AW-1:0]   s1_araddr,
    input  logic [7:0]      s1_arlen,
    input  logic [2:0]      s1_arsize,
    input  logic [1:0]      s1_arburst,
    input  logic [2:0]      s1_arprot,
    input  logic            s1_arvalid,
    output logic            s1_arready,
    output logic [DW-1:0]   s1_rdata,
    output logic [1:0]      s1_rresp,
    output logic            s1_rlast,
    output logic            s1_rvalid,
    input  logic            s1_rready,
    input  logic [AW-1:0]   s1_awaddr,
    input  logic [7:0]      s1_awlen,
    input  logic [2:0]      s1_awsize,
    input  logic [1:0]      s1_awburst,
    input  logic [2:0]      s1_awprot,
    input  logic            s1_awvalid,
    output logic            s1_awready,
    input  logic [DW-1:0]   s1_wdata,
    input  logic [DW/8-1:0] s1_wstrb,
    input  logic            s1_wlast,
    input  logic            s1_wvalid,
    output logic            s1_wready,
    output logic [1:0]      s1_bresp,
    output logic            s1_bvalid,
    input  logic            s1_bready,
    output logic [AW-1:0]   m_araddr,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    output logic [1:0]      m_arburst,
    output logic [2:0]      m_arprot,
    output logic [3:0]      m_arcache,
    output logic [4:0]      m_aruser,
    output logic            m_arvalid,
    input  logic            m_arready,
    input  logic [DW-1:0]   m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rlast,
    input  logic            m_rvalid,
    output logic            m_rready,
    output logic [AW-1:0]   m_awaddr,
    output logic [7:0]      m_awlen,
    output logic [2:0]      m_awsize,
    output logic [1:0]      m_awburst,
    output logic [2:0]      m_awprot,
    output logic [3:0]      m_awcache,
    output logic [4:0]      m_awuser,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    output logic            m_wlast,
    output logic            m_wvalid,
    input  logic            m_wready,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready
);

`ifdef ACP_ARB_COHERENT_EN
    localparam logic [3:0] CACHE_VAL = ACP_CACHE_COHERENT;
    localparam logic [4:0] USER_VAL  = ACP_USER_COHERENT;
`else
    localparam logic [3:0] CACHE_VAL = ACP_CACHE_DEFAULT;
    localparam logic [4:0] USER_VAL  = ACP_USER_DEFAULT;
`endif

    rd_state_t rd_state;
    wr_state_t wr_state;
    logic      rd_owner, rd_ptr, rd_gnt_valid, rd_gnt_id;
    logic      wr_owner, wr_ptr, wr_gnt_valid, wr_gnt_id;
    logic      rd_addr_ph, rd_data_ph, wr_addr_ph, wr_data_ph, wr_resp_ph;

    acp_rr_pick u_rd_pick (
        .req         ({s1_arvalid, s0_arvalid}),
        .ptr         (rd_ptr),
        .grant_valid (rd_gnt_valid),
        .grant_id    (rd_gnt_id)
    );

    acp_rr_pick u_wr_pick (
        .req         ({s1_awvalid, s0_awvalid}),
        .ptr         (wr_ptr),
        .grant_valid (wr_gnt_valid),
        .grant_id    (wr_gnt_id)
    );

    assign rd_addr_ph = (rd_state == RD_ADDR);
    assign rd_data_ph = (rd_state == RD_DATA);
    assign wr_addr_ph = (wr_state == WR_ADDR);
    assign wr_data_ph = (wr_state == WR_DATA);
    assign wr_resp_ph = (wr_state == WR_RESP);

    // Owner muxes are gated by phase so idle paths present all-zero outputs.
    assign m_araddr  = !rd_addr_ph ? '0 : (rd_owner ? s1_araddr  : s0_araddr);
    assign m_arlen   = !rd_addr_ph ? '0 : (rd_owner ? s1_arlen   : s0_arlen);
    assign m_arsize  = !rd_addr_ph ? '0 : (rd_owner ? s1_arsize  : s0_arsize);
    assign m_arburst = !rd_addr_ph ? '0 : (rd_owner ? s1_arburst : s0_arburst);
    assign m_arprot  = !rd_addr_ph ? '0 : (rd_owner ? s1_arprot  : s0_arprot);
    assign m_arvalid = rd_addr_ph & (rd_owner ? s1_arvalid : s0_arvalid);
    assign m_arcache = CACHE_VAL;
    assign m_aruser  = USER_VAL;
    assign m_rready  = rd_data_ph & (rd_owner ? s1_rready : s0_rready);

    assign s0_arready = rd_addr_ph & ~rd_owner & m_arready;
    assign s1_arready = rd_addr_ph &  rd_owner & m_arready;
    assign s0_rvalid  = rd_data_ph & ~rd_owner & m_rvalid;
    assign s1_rvalid  = rd_data_ph &  rd_owner & m_rvalid;
    assign s0_rdata   = (rd_data_ph & ~rd_owner) ? m_rdata : '0;
    assign s1_rdata   = (rd_data_ph &  rd_owner) ? m_rdata : '0;
    assign s0_rresp   = (rd_data_ph & ~rd_owner) ? m_rresp : '0;
    assign s1_rresp   = (rd_data_ph &  rd_owner) ? m_rresp : '0;
    assign s0_rlast   = rd_data_ph & ~rd_owner & m_rlast;
    assign s1_rlast   = rd_data_ph &  rd_owner & m_rlast;

    assign m_awaddr  = !wr_addr_ph ? '0 : (wr_owner ? s1_awaddr  : s0_awaddr);
    assign m_awlen   = !wr_addr_ph ? '0 : (wr_owner ? s1_awlen   : s0_awlen);
    assign m_awsize  = !wr_addr_ph ? '0 : (wr_owner ? s1_awsize  : s0_awsize);
    assign m_awburst = !wr_addr_ph ? '0 : (wr_owner ? s1_awburst : s0_awburst);
    assign m_awprot  = !wr_addr_ph ? '0 : (wr_owner ? s1_awprot  : s0_awprot);
    assign m_awvalid = wr_addr_ph & (wr_owner ? s1_awvalid : s0_awvalid);
    assign m_awcache = CACHE_VAL;
    assign m_awuser  = USER_VAL;
    assign m_wdata   = !wr_data_ph ? '0 : (wr_owner ? s1_wdata : s0_wdata);
    assign m_wstrb   = !wr_data_ph ? '0 : (wr_owner ? s1_wstrb : s0_wstrb);
    assign m_wlast   = wr_data_ph & (wr_owner ? s1_wlast  : s0_wlast);
    assign m_wvalid  = wr_data_ph & (wr_owner ? s1_wvalid : s0_wvalid);
    assign m_bready  = wr_resp_ph & (wr_owner ? s1_bready : s0_bready);

    assign s0_awready = wr_addr_ph & ~wr_owner & m_awready;
    assign s1_awready = wr_addr_ph &  wr_owner & m_awready;
    assign s0_wready  = wr_data_ph & ~wr_owner & m_wready;
    assign s1_wready  = wr_data_ph &  wr_owner & m_wready;
    assign s0_bvalid  = wr_resp_ph & ~wr_owner & m_bvalid;
    assign s1_bvalid  = wr_resp_ph &  wr_owner & m_bvalid;
    assign s0_bresp   = (wr_resp_ph & ~wr_owner) ? m_bresp : '0;
    assign s1_bresp   = (wr_resp_ph &  wr_owner) ? m_bresp : '0;

    // Pointer moves to the other requester only once a whole burst retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_owner <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: if (rd_gnt_valid) begin
                    rd_owner <= rd_gnt_id;
                    rd_state <= RD_ADDR;
                end
                RD_ADDR: if (m_arvalid && m_arready) rd_state <= RD_DATA;
                RD_DATA: if (m_rvalid && m_rready && m_rlast) begin
                    rd_state <= RD_IDLE;
                    rd_ptr   <= ~rd_owner;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= WR_IDLE;
            wr_owner <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: if (wr_gnt_valid) begin
                    wr_owner <= wr_gnt_id;
                    wr_state <= WR_ADDR;
                end
                WR_ADDR: if (m_awvalid && m_awready) wr_state <= WR_DATA;
                WR_DATA: if (m_wvalid && m_wready && m_wlast) wr_state <= WR_RESP;
                WR_RESP: if (m_bvalid && m_bready) begin
                    wr_state <= WR_IDLE;
                    wr_ptr   <= ~wr_owner;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

endmodule
